pe_accumulator: RTL and testbench

Downstream stage of the 8-input pipelined PE tree adder. Accumulates successive 8-product partial sums from one PE into a full neuron dot product over a configurable number of chunks. Adds the neuron bias and saturates to WIDTH. Hands the result to the activation/writeback stage over a valid/ready handshake.

---
 rtl/pe_accumulator.sv | 148 ++++++++++++++
 tb/tb_pe_accumulator.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_accumulator.sv
// pe_accumulator
// ---------------------------------------------------------------------------
// Accumulates a configurable number of 8-product partial sums from one PE
// tree adder into a full neuron dot product. The neuron bias is added, the
// result is saturated to WIDTH bits, and it is handed downstream over a
// valid/ready handshake.
//
// Optional feature: define PE_ACC_RELU_EN to clamp negative saturated
// results to zero (ReLU). Without it, the saturated signed value passes
// through unchanged.
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   synchronous active-low reset
//   start       in   begin a new neuron (accepted only when idle)
//   num_chunks  in   [CNT_W] number of PE results to sum (0 treated as 1)
//   bias        in   [WIDTH] neuron bias, sampled with start
//   in_valid    in   in_data carries a PE result
//   in_data     in   [WIDTH] PE tree-adder result
//   out_valid   out  out_data holds a completed neuron result
//   out_ready   in   downstream accepts out_data
//   out_data    out  [WIDTH] saturated (optionally ReLU'd) result, registered
//   busy        out  neuron in progress (accumulating or presenting result)
//   err         out  sticky: in_valid seen while not accumulating
// ---------------------------------------------------------------------------
module pe_accumulator #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8,
  parameter int ACC_W = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_chunks,
  input  logic [WIDTH-1:0] bias,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  state_t                  state_q, state_d;
  logic        [CNT_W-1:0] n_q, n_d;
  logic        [CNT_W-1:0] cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] sum;
  logic        [WIDTH-1:0] out_data_q, out_data_d;
  logic                    err_q, err_d;

  function automatic logic signed [ACC_W-1:0] sext(input logic [WIDTH-1:0] v);
    return {{(ACC_W-WIDTH){v[WIDTH-1]}}, v};
  endfunction

  function automatic logic [WIDTH-1:0] saturate(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX)      return {1'b0, {(WIDTH-1){1'b1}}};
    else if (v < SAT_MIN) return {1'b1, {(WIDTH-1){1'b0}}};
    else                  return v[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] activate(input logic [WIDTH-1:0] v);
`ifdef PE_ACC_RELU_EN
    if (v[WIDTH-1]) return '0;
    else            return v;
`else
    return v;
`endif
  endfunction

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    err_d      = err_q;
    // The ACC_W sizing guarantees this sum never wraps, so saturation is
    // only needed once, on the final total.
    sum        = acc_q + sext(in_data);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d     = (num_chunks == '0) ? CNT_W'(1) : num_chunks;
          acc_d   = sext(bias);
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        if (in_valid) begin
          acc_d = sum;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == n_q - CNT_W'(1)) begin
            out_data_d = activate(saturate(sum));
            state_d    = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A beat arriving while not accumulating is dropped but flagged; this
    // also covers the start cycle itself, so it wins over the start clear.
    if (in_valid && state_q != S_ACC) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      err_q      <= err_d;
    end
  end

  assign out_valid = (state_q == S_OUT);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = out_data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_pe_accumulator.sv
// tb_pe_accumulator
// Directed bench for pe_accumulator: a table of neuron vectors with
// hand-computed results, plus hand-written sequences for back-pressure,
// error flag handling, ignored start, and reset in the middle of a neuron.
module tb_pe_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  num_chunks;
  logic [15:0] bias;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;
  logic        err;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pe_accumulator #(.WIDTH(16), .CNT_W(8), .ACC_W(25)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_chunks (num_chunks),
    .bias       (bias),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .err        (err)
  );

  typedef struct {
    logic [7:0]       n;
    logic [15:0]      bias;
    int               nb;
    logic [3:0][15:0] beats;
    logic [15:0]      exp;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(input logic [7:0] n, input logic [15:0] b,
                              input int nb, input logic [15:0] b0,
                              input logic [15:0] b1, input logic [15:0] b2,
                              input logic [15:0] b3, input logic [15:0] e);
    vec_t v;
    v.n = n; v.bias = b; v.nb = nb;
    v.beats[0] = b0; v.beats[1] = b1; v.beats[2] = b2; v.beats[3] = b3;
    v.exp = e;
    return v;
  endfunction

  // Hand-computed signed results; with ReLU built in, negatives read as 0.
  function automatic logic [15:0] relu_exp(input logic [15:0] v);
`ifdef PE_ACC_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] n, input logic [15:0] b);
    start = 1'b1; num_chunks = n; bias = b;
    tick();
    start = 1'b0; num_chunks = 8'hAA; bias = 16'hDEAD;
  endtask

  task automatic beat(input logic [15:0] d);
    in_valid = 1'b1; in_data = d;
    tick();
    in_valid = 1'b0; in_data = 16'hBEEF;
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({name, ".valid_after_hs"}, 32'(out_valid), 32'd0);
    chk({name, ".busy_after_hs"}, 32'(busy), 32'd0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string nm;
    nm = $sformatf("vec%0d", idx);
    do_start(v.n, v.bias);
    chk({nm, ".busy_start"}, 32'(busy), 32'd1);
    for (int i = 0; i < v.nb; i++) begin
      if (i % 2 == 1) tick();  // idle gap between beats
      chk($sformatf("%s.valid_before_beat%0d", nm, i), 32'(out_valid), 32'd0);
      beat(v.beats[i]);
    end
    chk({nm, ".valid"}, 32'(out_valid), 32'd1);
    chk({nm, ".data"}, 32'(out_data), 32'(v.exp));
    handshake(nm);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; num_chunks = '0; bias = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    vecs[0] = mk(8'd3, 16'h0010, 3, 16'h0100, 16'h0200, 16'hFFFF, 16'h0, 16'h030F);
    vecs[1] = mk(8'd2, 16'h7000, 2, 16'h7000, 16'h7000, 16'h0, 16'h0, 16'h7FFF);
    vecs[2] = mk(8'd1, 16'h8000, 1, 16'h8000, 16'h0, 16'h0, 16'h0, relu_exp(16'h8000));
    vecs[3] = mk(8'd0, 16'h0005, 1, 16'h0007, 16'h0, 16'h0, 16'h0, 16'h000C);
    vecs[4] = mk(8'd4, 16'hFFF0, 4, 16'h0001, 16'h0002, 16'h0003, 16'h0004, relu_exp(16'hFFFA));
    vecs[5] = mk(8'd2, 16'h0000, 2, 16'h8000, 16'hFFFF, 16'h0, 16'h0, relu_exp(16'h8000));
    vecs[6] = mk(8'd2, 16'h7FFF, 2, 16'h8001, 16'h0000, 16'h0, 16'h0, 16'h0000);
    vecs[7] = mk(8'd3, 16'h0000, 3, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h0, 16'h7FFE);

    // Reset with random inputs toggling
    for (int i = 0; i < 2; i++) begin
      start = 1'($urandom); in_valid = 1'($urandom); out_ready = 1'($urandom);
      in_data = 16'($urandom); bias = 16'($urandom); num_chunks = 8'($urandom);
      tick();
    end
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data", 32'(out_data), 32'h0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b1;
    tick();

    // Table-driven neurons
    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Back-pressure: result held while out_ready=0; start in OUT ignored
    do_start(8'd3, 16'h0010);
    beat(16'h0100);
    tick();
    beat(16'h0200);
    tick(); tick();
    beat(16'hFFFF);
    chk("bp.valid", 32'(out_valid), 32'd1);
    chk("bp.data", 32'(out_data), 32'h030F);
    for (int i = 0; i < 3; i++) begin
      start = (i == 1); num_chunks = 8'd1; bias = 16'h1111;
      tick();
      chk($sformatf("bp.hold_valid%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp.hold_data%0d", i), 32'(out_data), 32'h030F);
      chk($sformatf("bp.hold_busy%0d", i), 32'(busy), 32'd1);
    end
    start = 1'b0;
    handshake("bp");

    // Stray beat in IDLE sets err and does not disturb the next sum
    beat(16'h1234);
    chk("err.idle_set", 32'(err), 32'd1);
    do_start(8'd1, 16'h0000);
    chk("err.start_clr", 32'(err), 32'd0);
    // start during ACC is ignored: n stays 1, bias stays 0
    do_start(8'd5, 16'h1000);
    chk("ign.busy", 32'(busy), 32'd1);
    beat(16'h0003);
    chk("ign.valid", 32'(out_valid), 32'd1);
    chk("ign.data", 32'(out_data), 32'h0003);
    chk("ign.err_acc", 32'(err), 32'd0);
    // Beat during OUT sets err, result unchanged
    beat(16'h0777);
    chk("err.out_set", 32'(err), 32'd1);
    chk("err.out_data", 32'(out_data), 32'h0003);
    handshake("err");
    // in_valid in the start cycle: clears then re-flags err, data ignored
    start = 1'b1; num_chunks = 8'd1; bias = 16'h0002;
    in_valid = 1'b1; in_data = 16'h0100;
    tick();
    start = 1'b0; in_valid = 1'b0;
    chk("err.start_cycle", 32'(err), 32'd1);
    beat(16'h0001);
    chk("sc.data", 32'(out_data), 32'h0003);
    handshake("sc");

    // Reset in the middle of accumulation
    do_start(8'd3, 16'h0000);
    beat(16'h0005);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid.busy", 32'(busy), 32'd0);
    chk("mid.valid", 32'(out_valid), 32'd0);
    chk("mid.err", 32'(err), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mid.no_valid%0d", i), 32'(out_valid), 32'd0);
    end
    do_start(8'd2, 16'h0001);
    beat(16'h0002);
    beat(16'h0003);
    chk("mid.fresh_valid", 32'(out_valid), 32'd1);
    chk("mid.fresh_data", 32'(out_data), 32'h0006);
    handshake("mid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
